// File: rtl/v_mult_su_pipe_if.sv
// Request/result bundle for the pipelined SIMD multiplier.
// The mask signal exists only when VMUL_MASK_EN is defined.
interface v_mult_su_pipe_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [1:0]      opcode;
  logic [1:0]      precision;
`ifdef VMUL_MASK_EN
  logic [XLEN/8-1:0] mask;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] mul_out;
  logic            out_err;

  modport master (
`ifdef VMUL_MASK_EN
    output mask,
`endif
    output in_valid, operand_a, operand_b, opcode, precision, out_ready,
    input  in_ready, out_valid, mul_out, out_err
  );

  modport slave (
`ifdef VMUL_MASK_EN
    input  mask,
`endif
    input  in_valid, operand_a, operand_b, opcode, precision, out_ready,
    output in_ready, out_valid, mul_out, out_err
  );
endinterface

// File: rtl/v_mult_su_pipe.sv
// Pipelined packed-SIMD multiplier (mul/mulh/mulhu/mulhsu, SEW 8/16/32[/64]).
// Optional per-element masking is enabled with the VMUL_MASK_EN macro.
module v_mult_su_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  v_mult_su_pipe_if.slave bus
);

  localparam int PW = 2 * XLEN;

  logic stall;

  logic            s1_valid;
  logic [XLEN-1:0] s1_a;
  logic [XLEN-1:0] s1_b;
  logic [1:0]      s1_op;
  logic [1:0]      s1_prec;
  logic            s1_err;

  logic            s2_valid;
  logic [PW-1:0]   s2_prod;
  logic            s2_hi;
  logic [1:0]      s2_prec;
  logic            s2_err;

  logic            out_valid_q;
  logic [XLEN-1:0] mul_out_q;
  logic            out_err_q;

`ifdef VMUL_MASK_EN
  logic [XLEN/8-1:0] s1_mask;
  logic [XLEN/8-1:0] s2_mask;
`endif

  logic               sign_a;
  logic               sign_b;
  logic [3:0][PW-1:0]   prod_w;
  logic [PW-1:0]        prod_sel;
  logic [3:0][XLEN-1:0] pack_w;
  logic [XLEN-1:0]      pack_sel;

  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = rst && !stall;

  assign sign_a = (s1_op == 2'b01) || (s1_op == 2'b11);
  assign sign_b = (s1_op == 2'b01);

  // Each operand is extended to 2*SEW bits (sign or zero per opcode); the
  // low 2*SEW bits of that product equal the exact mixed-sign product.
  for (genvar w = 0; w < 4; w++) begin : g_prod
    localparam int SEW = 8 << w;
    if (SEW <= XLEN) begin : g_on
      for (genvar e = 0; e < XLEN / SEW; e++) begin : g_elem
        logic [2*SEW-1:0] ext_a;
        logic [2*SEW-1:0] ext_b;
        logic [2*SEW-1:0] prod;
        assign ext_a = {{SEW{sign_a & s1_a[e*SEW+SEW-1]}}, s1_a[e*SEW +: SEW]};
        assign ext_b = {{SEW{sign_b & s1_b[e*SEW+SEW-1]}}, s1_b[e*SEW +: SEW]};
        assign prod  = ext_a * ext_b;
        assign prod_w[w][e*2*SEW +: 2*SEW] = prod;
      end
    end else begin : g_off
      assign prod_w[w] = '0;
    end
  end

  always_comb begin
    prod_sel = '0;
    case (s1_prec)
      2'b00:   prod_sel = prod_w[0];
      2'b01:   prod_sel = prod_w[1];
      2'b10:   prod_sel = prod_w[2];
      default: prod_sel = prod_w[3];
    endcase
  end

  for (genvar w = 0; w < 4; w++) begin : g_pack
    localparam int SEW = 8 << w;
    if (SEW <= XLEN) begin : g_on
      for (genvar e = 0; e < XLEN / SEW; e++) begin : g_elem
        logic [SEW-1:0] half;
        assign half = s2_hi ? s2_prod[e*2*SEW+SEW +: SEW] : s2_prod[e*2*SEW +: SEW];
`ifdef VMUL_MASK_EN
        assign pack_w[w][e*SEW +: SEW] = half & {SEW{s2_mask[e]}};
`else
        assign pack_w[w][e*SEW +: SEW] = half;
`endif
      end
    end else begin : g_off
      assign pack_w[w] = '0;
    end
  end

  always_comb begin
    pack_sel = '0;
    case (s2_prec)
      2'b00:   pack_sel = pack_w[0];
      2'b01:   pack_sel = pack_w[1];
      2'b10:   pack_sel = pack_w[2];
      default: pack_sel = pack_w[3];
    endcase
  end

  // Valid bits and outputs: cleared by reset, frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      mul_out_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (!stall) begin
      s1_valid    <= bus.in_valid;
      s2_valid    <= s1_valid;
      out_valid_q <= s2_valid;
      mul_out_q   <= (s2_valid && !s2_err) ? pack_sel : '0;
      out_err_q   <= s2_valid && s2_err;
    end
  end

  // Payload registers only load behind a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (bus.in_valid) begin
        s1_a    <= bus.operand_a;
        s1_b    <= bus.operand_b;
        s1_op   <= bus.opcode;
        s1_prec <= bus.precision;
        s1_err  <= (bus.precision == 2'b11) && (XLEN == 32);
`ifdef VMUL_MASK_EN
        s1_mask <= bus.mask;
`endif
      end
      if (s1_valid) begin
        s2_prod <= prod_sel;
        s2_hi   <= (s1_op != 2'b00);
        s2_prec <= s1_prec;
        s2_err  <= s1_err;
`ifdef VMUL_MASK_EN
        s2_mask <= s1_mask;
`endif
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.mul_out   = mul_out_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_v_mult_su_pipe.sv
// Directed bench for v_mult_su_pipe at XLEN=32; the mask case runs when
// VMUL_MASK_EN is defined.
module tb_v_mult_su_pipe;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] CA = 32'h0f05561f;
  localparam logic [31:0] CB = 32'h04b58300;
  localparam logic [31:0] DA = 32'hFFFFFFFF;
  localparam logic [31:0] DB = 32'h02020202;

  logic [31:0] e1 [4] = '{32'hB289DD00, 32'h0046D5F2, 32'h00462C11, 32'h00462C11};
  logic [31:0] e2 [4] = '{32'hFEFEFEFE, 32'hFFFFFFFF, 32'h01010101, 32'hFFFFFFFF};
  logic [31:0] exp_s [8];

  v_mult_su_pipe_if #(.XLEN(XLEN)) bus ();

  v_mult_su_pipe #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [1:0] pr);
    bus.operand_a = a;
    bus.operand_b = b;
    bus.opcode    = op;
    bus.precision = pr;
    bus.in_valid  = 1'b1;
  endtask

  // Starts and ends on a falling edge with an empty pipe and out_ready=1.
  task automatic one_shot(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [1:0] pr,
                          input logic [31:0] exp, input logic exp_err);
    drive(a, b, op, pr);
    chk({tag, "_rdy"}, bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, bus.out_valid, 0);
    @(negedge clk);
    chk({tag, "_lat2"}, bus.out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, bus.out_valid, 1);
    chk({tag, "_dat"}, bus.mul_out, exp);
    chk({tag, "_err"}, bus.out_err, exp_err);
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.opcode    = 2'b00;
    bus.precision = 2'b00;
`ifdef VMUL_MASK_EN
    bus.mask      = '1;
`endif

    // reset state
    @(negedge clk);
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_dat", bus.mul_out, 0);
    chk("rst_err", bus.out_err, 0);
    rst = 1'b1;
    #1 chk("rel_rdy", bus.in_ready, 1);
    @(negedge clk);

    // SEW=16 and SEW=8 opcode sweeps
    for (int k = 0; k < 4; k++) begin
      one_shot($sformatf("h16_op%0d", k), CA, CB, k[1:0], 2'b01, e1[k], 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      one_shot($sformatf("b8_op%0d", k), DA, DB, k[1:0], 2'b00, e2[k], 1'b0);
    end

    // SEW=32
    one_shot("w32_mul",    32'hFFFFFFFF, 32'h00000002, 2'b00, 2'b10, 32'hFFFFFFFE, 1'b0);
    one_shot("w32_mulhu",  32'hFFFFFFFF, 32'h00000002, 2'b10, 2'b10, 32'h00000001, 1'b0);
    one_shot("w32_mulh",   32'h80000000, 32'h80000000, 2'b01, 2'b10, 32'h40000000, 1'b0);
    one_shot("w32_mulhsu", 32'h80000000, 32'h80000000, 2'b11, 2'b10, 32'hC0000000, 1'b0);

    // illegal precision, then a legal request
    one_shot("ill_prec", CA, CB, 2'b00, 2'b11, 32'h00000000, 1'b1);
    one_shot("post_ill", CA, CB, 2'b00, 2'b01, 32'hB289DD00, 1'b0);

    // back-to-back with alternating precision
    for (int i = 0; i < 8; i++) begin
      exp_s[i] = (i % 2 == 0) ? e1[i/2] : e2[i/2];
    end
    for (int j = 0; j < 12; j++) begin
      if (j >= 3) begin
        chk($sformatf("strm_v%0d", j), bus.out_valid, (j < 11) ? 1 : 0);
        if (j < 11) chk($sformatf("strm_d%0d", j), bus.mul_out, exp_s[j-3]);
      end
      if (j < 8) begin
        if (j % 2 == 0) drive(CA, CB, 2'((j/2)), 2'b01);
        else            drive(DA, DB, 2'((j/2)), 2'b00);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // backpressure with two results in flight and a third waiting
    drive(CA, CB, 2'b00, 2'b01);
    @(negedge clk);
    drive(DA, DB, 2'b10, 2'b00);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(CA, CB, 2'b11, 2'b01);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stl_v%0d", k), bus.out_valid, 1);
      chk($sformatf("stl_d%0d", k), bus.mul_out, 32'hB289DD00);
      chk($sformatf("stl_r%0d", k), bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 chk("unstl_rdy", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("unstl_v1", bus.out_valid, 1);
    chk("unstl_d1", bus.mul_out, 32'h01010101);
    @(negedge clk);
    chk("unstl_bub", bus.out_valid, 0);
    @(negedge clk);
    chk("unstl_v2", bus.out_valid, 1);
    chk("unstl_d2", bus.mul_out, 32'h00462C11);
    @(negedge clk);

    // reset while stalled with two requests in flight
    drive(CA, CB, 2'b01, 2'b01);
    @(negedge clk);
    drive(DA, DB, 2'b00, 2'b00);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_v", bus.out_valid, 1);
    chk("pre_rst_d", bus.mul_out, 32'h0046D5F2);
    rst = 1'b0;
    drive(CA, CB, 2'b00, 2'b01);
    #1 chk("in_rst_rdy", bus.in_ready, 0);
    @(negedge clk);
    chk("post_rst_v", bus.out_valid, 0);
    chk("post_rst_d", bus.mul_out, 0);
    chk("post_rst_e", bus.out_err, 0);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1 chk("post_rst_rdy", bus.in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("no_stale%0d", k), bus.out_valid, 0);
    end

`ifdef VMUL_MASK_EN
    bus.mask = 4'b0001;
    one_shot("mask_e0", CA, CB, 2'b00, 2'b01, 32'h0000DD00, 1'b0);
    bus.mask = '1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
